// File: rtl/popcount_accum_threshold.sv
// -----------------------------------------------------------------------------
// popcount_accum_threshold
//
// Consumer of the 1024-bit popcount stage in the binarized-neuron datapath.
// It sums the per-chunk popcounts of one neuron over a configurable number of
// chunks. It then compares the neuron total against an unsigned threshold and
// hands {activation bit, raw sum} to the activation buffer over valid/ready.
//
// Optional feature macro: POPACC_SAT_EN
//   defined   : the accumulator saturates at 2^ACC_WIDTH-1, and the extra
//               output out_sat flags a neuron in which any addition saturated.
//   undefined : the accumulator wraps modulo 2^ACC_WIDTH, and out_sat does
//               not exist.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous reset, active-high
//   cfg_chunks     in   chunks per neuron (0 behaves as 1)
//   cfg_threshold  in   activation threshold (unsigned)
//   in_valid       in   in_count carries a chunk popcount
//   in_count       in   chunk popcount
//   in_ready       out  a chunk is accepted this cycle if in_valid is high
//   out_valid      out  neuron result available
//   out_ready      in   downstream takes the result
//   out_bit        out  1 when out_sum >= latched threshold
//   out_sum        out  accumulated neuron popcount
//   out_sat        out  (POPACC_SAT_EN only) saturation occurred in this neuron
//   busy           out  a neuron is partially accumulated
// -----------------------------------------------------------------------------
module popcount_accum_threshold #(
    parameter int IN_WIDTH        = 11,
    parameter int ACC_WIDTH       = 20,
    parameter int CHUNK_CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHUNK_CNT_WIDTH-1:0] cfg_chunks,
    input  logic [ACC_WIDTH-1:0]       cfg_threshold,
    input  logic                       in_valid,
    input  logic [IN_WIDTH-1:0]        in_count,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_bit,
    output logic [ACC_WIDTH-1:0]       out_sum,
`ifdef POPACC_SAT_EN
    output logic                       out_sat,
`endif
    output logic                       busy
);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    typedef logic [CHUNK_CNT_WIDTH:0] cnt_ext_t;

    state_t                     state_q;
    logic [ACC_WIDTH-1:0]       acc_q;
    logic [ACC_WIDTH-1:0]       thr_q;
    logic [ACC_WIDTH-1:0]       out_sum_q;
    logic [CHUNK_CNT_WIDTH-1:0] chunk_idx_q;
    logic [CHUNK_CNT_WIDTH-1:0] n_chunks_q;
    logic                       out_valid_q;
    logic                       out_bit_q;

    logic                       accept;
    logic                       first;
    logic                       last;
    logic [CHUNK_CNT_WIDTH-1:0] n_eff;
    logic [ACC_WIDTH-1:0]       thr_eff;
    logic [ACC_WIDTH-1:0]       base;
    logic [ACC_WIDTH-1:0]       acc_d;
    logic                       bit_d;

`ifdef POPACC_SAT_EN
    logic sat_q;        // running "some add saturated" flag for this neuron
    logic out_sat_q;
    logic sat_d;
    logic add_carry;

    // Returns {saturated, sum}; the sum clamps to all-ones on carry-out.
    function automatic logic [ACC_WIDTH:0] add_sat(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [IN_WIDTH-1:0]  b);
        logic [ACC_WIDTH:0] full;
        full = {1'b0, a} + (ACC_WIDTH+1)'(b);
        if (full[ACC_WIDTH]) begin
            return {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return full;
    endfunction
`else
    function automatic logic [ACC_WIDTH-1:0] add_wrap(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [IN_WIDTH-1:0]  b);
        return a + ACC_WIDTH'(b);
    endfunction
`endif

    always_comb begin
        // While in EMIT, back-pressure from the output passes straight to the input.
        in_ready = rst ? 1'b1 : ((state_q == ACCUM) ? 1'b1 : out_ready);
        busy     = !rst && (state_q == ACCUM) && (chunk_idx_q != '0);
        accept   = in_valid && in_ready;

        // A chunk arriving at index 0 opens a new neuron. It uses the live config,
        // which the register block latches for the remaining chunks.
        first   = (chunk_idx_q == '0);
        n_eff   = first ? ((cfg_chunks == '0) ? CHUNK_CNT_WIDTH'(1) : cfg_chunks)
                        : n_chunks_q;
        thr_eff = first ? cfg_threshold : thr_q;
        base    = first ? '0 : acc_q;

`ifdef POPACC_SAT_EN
        {add_carry, acc_d} = add_sat(base, in_count);
        sat_d              = (first ? 1'b0 : sat_q) | add_carry;
`else
        acc_d = add_wrap(base, in_count);
`endif

        // Compare one bit wider so that n_chunks = 2^W-1 cannot wrap.
        last  = (cnt_ext_t'(chunk_idx_q) + cnt_ext_t'(1)) == cnt_ext_t'(n_eff);
        bit_d = (acc_d >= thr_eff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            thr_q       <= '0;
            n_chunks_q  <= '0;
            chunk_idx_q <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_sum_q   <= '0;
`ifdef POPACC_SAT_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else if (accept) begin
            // In EMIT, an accept implies out_ready: the old result retires now.
            acc_q <= acc_d;
`ifdef POPACC_SAT_EN
            sat_q <= sat_d;
`endif
            if (first) begin
                n_chunks_q <= n_eff;
                thr_q      <= thr_eff;
            end
            if (last) begin
                state_q     <= EMIT;
                out_valid_q <= 1'b1;
                out_sum_q   <= acc_d;
                out_bit_q   <= bit_d;
`ifdef POPACC_SAT_EN
                out_sat_q   <= sat_d;
`endif
                chunk_idx_q <= '0;
            end else begin
                state_q     <= ACCUM;
                out_valid_q <= 1'b0;
                chunk_idx_q <= chunk_idx_q + CHUNK_CNT_WIDTH'(1);
            end
        end else if ((state_q == EMIT) && out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_sum   = out_sum_q;
`ifdef POPACC_SAT_EN
    assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_popcount_accum_threshold.sv
// -----------------------------------------------------------------------------
// Directed testbench for popcount_accum_threshold.
// Instance dut uses the default widths. Instance dut_b uses ACC_WIDTH=11 to
// exercise accumulator overflow (wrap or saturate, depending on POPACC_SAT_EN).
// -----------------------------------------------------------------------------
module tb_popcount_accum_threshold;

    localparam int IW  = 11;
    localparam int AW  = 20;
    localparam int CW  = 8;
    localparam int AWB = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [CW-1:0] cfg_chunks;
    logic [AW-1:0] cfg_threshold;
    logic          in_valid;
    logic [IW-1:0] in_count;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic [AW-1:0] out_sum;
    logic          busy;

    logic           b_rst;
    logic [CW-1:0]  b_cfg_chunks;
    logic [AWB-1:0] b_cfg_threshold;
    logic           b_in_valid;
    logic [IW-1:0]  b_in_count;
    logic           b_in_ready;
    logic           b_out_valid;
    logic           b_out_ready;
    logic           b_out_bit;
    logic [AWB-1:0] b_out_sum;
    logic           b_busy;

`ifdef POPACC_SAT_EN
    logic out_sat;
    logic b_out_sat;
`endif

    popcount_accum_threshold #(
        .IN_WIDTH(IW), .ACC_WIDTH(AW), .CHUNK_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_chunks(cfg_chunks), .cfg_threshold(cfg_threshold),
        .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_sum(out_sum),
`ifdef POPACC_SAT_EN
        .out_sat(out_sat),
`endif
        .busy(busy)
    );

    popcount_accum_threshold #(
        .IN_WIDTH(IW), .ACC_WIDTH(AWB), .CHUNK_CNT_WIDTH(CW)
    ) dut_b (
        .clk(clk), .rst(b_rst), .cfg_chunks(b_cfg_chunks), .cfg_threshold(b_cfg_threshold),
        .in_valid(b_in_valid), .in_count(b_in_count), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
        .out_sum(b_out_sum),
`ifdef POPACC_SAT_EN
        .out_sat(b_out_sat),
`endif
        .busy(b_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        cfg_chunks      = 8'd0;
        cfg_threshold   = 20'd0;
        in_valid        = 1'b0;
        in_count        = 11'd0;
        out_ready       = 1'b1;
        b_rst           = 1'b1;
        b_cfg_chunks    = 8'd2;
        b_cfg_threshold = 11'd2000;
        b_in_valid      = 1'b0;
        b_in_count      = 11'd0;
        b_out_ready     = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        rst   = 1'b0;
        b_rst = 1'b0;
        tick();

        // Basic 4-chunk neuron: 512+600+400+500 = 2012 >= 2000
        cfg_chunks    = 8'd4;
        cfg_threshold = 20'd2000;
        begin
            logic [IW-1:0] c4 [4];
            c4[0] = 11'd512; c4[1] = 11'd600; c4[2] = 11'd400; c4[3] = 11'd500;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_count = c4[i];
                #1;
                check("basic_busy", 32'(busy), (i != 0) ? 32'd1 : 32'd0);
                check("basic_in_ready", 32'(in_ready), 32'd1);
                check("basic_no_valid_yet", 32'(out_valid), 32'd0);
                tick();
            end
        end
        in_valid = 1'b0;
        check("basic_out_valid", 32'(out_valid), 32'd1);
        check("basic_out_sum", 32'(out_sum), 32'd2012);
        check("basic_out_bit", 32'(out_bit), 32'd1);
`ifdef POPACC_SAT_EN
        check("basic_out_sat", 32'(out_sat), 32'd0);
`endif
        tick();
        check("basic_retired", 32'(out_valid), 32'd0);

        // Below threshold with back-pressure: 1400 < 1500
        cfg_chunks    = 8'd2;
        cfg_threshold = 20'd1500;
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_count      = 11'd700;
        tick();
        tick();
        in_count = 11'd5;    // pending chunk that must wait for the stall to clear
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_sum", 32'(out_sum), 32'd1400);
            check("bp_out_bit", 32'(out_bit), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_new_neuron_accum", 32'(out_valid), 32'd0);
        check("bp_new_neuron_busy", 32'(busy), 32'd1);
        in_count = 11'd6;
        tick();
        in_valid = 1'b0;
        check("bp_followup_sum", 32'(out_sum), 32'd11);
        check("bp_followup_bit", 32'(out_bit), 32'd0);
        tick();

        // Back-to-back 1-chunk neurons (cfg_chunks=0 behaves as 1)
        cfg_chunks    = 8'd0;
        cfg_threshold = 20'd10;
        begin
            logic [IW-1:0] c1 [3];
            logic [31:0]   eb [3];
            c1[0] = 11'd9;  c1[1] = 11'd10; c1[2] = 11'd1024;
            eb[0] = 32'd0;  eb[1] = 32'd1;  eb[2] = 32'd1;
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_count = c1[i];
                #1;
                check("b2b_in_ready", 32'(in_ready), 32'd1);
                tick();
                check("b2b_out_valid", 32'(out_valid), 32'd1);
                check("b2b_out_sum", 32'(out_sum), 32'(c1[i]));
                check("b2b_out_bit", 32'(out_bit), eb[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        check("b2b_retired", 32'(out_valid), 32'd0);

        // Mid-neuron config change has no effect: 50+30+30 = 110 >= 100
        cfg_chunks    = 8'd3;
        cfg_threshold = 20'd100;
        in_valid      = 1'b1;
        in_count      = 11'd50;
        tick();
        cfg_chunks    = 8'd1;
        cfg_threshold = 20'd1000;
        in_count      = 11'd30;
        #1;
        check("cfg_busy", 32'(busy), 32'd1);
        tick();
        check("cfg_not_done", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("cfg_out_valid", 32'(out_valid), 32'd1);
        check("cfg_out_sum", 32'(out_sum), 32'd110);
        check("cfg_out_bit", 32'(out_bit), 32'd1);
        tick();

        // Reset mid-neuron discards the partial sum
        cfg_chunks    = 8'd4;
        cfg_threshold = 20'd400;
        in_valid      = 1'b1;
        in_count      = 11'd100;
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_busy_forced", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_count = 11'd100;
            #1;
            check("midrst_no_stale", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midrst_out_sum", 32'(out_sum), 32'd400);
        check("midrst_out_bit", 32'(out_bit), 32'd1);
        // Reset while a result is pending drops it
        tick();
        check("emitrst_held", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("emitrst_out_valid", 32'(out_valid), 32'd0);
        check("emitrst_out_sum", 32'(out_sum), 32'd0);
        tick();

        // Largest chunk count: 255 chunks of 1, threshold equal to sum
        cfg_chunks    = 8'd255;
        cfg_threshold = 20'd255;
        in_count      = 11'd1;
        for (int i = 0; i < 255; i++) begin
            in_valid = 1'b1;
            tick();
            if (i == 253) check("max_not_done", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("max_out_valid", 32'(out_valid), 32'd1);
        check("max_out_sum", 32'(out_sum), 32'd255);
        check("max_out_bit", 32'(out_bit), 32'd1);
        tick();

        // Overflow on the 11-bit accumulator: 1024 + 1024
        b_in_valid = 1'b1;
        b_in_count = 11'd1024;
        tick();
        tick();
        b_in_valid = 1'b0;
        check("ovf_out_valid", 32'(b_out_valid), 32'd1);
`ifdef POPACC_SAT_EN
        check("ovf_out_sum", 32'(b_out_sum), 32'd2047);
        check("ovf_out_bit", 32'(b_out_bit), 32'd1);
        check("ovf_out_sat", 32'(b_out_sat), 32'd1);
`else
        check("ovf_out_sum", 32'(b_out_sum), 32'd0);
        check("ovf_out_bit", 32'(b_out_bit), 32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_accum_threshold.md
Name: popcount_accum_threshold

Overview:
- Downstream consumer of the 1024-bit popcount stage in the binarized-neuron datapath.
- Accumulates the per-chunk popcount results of one neuron over a configurable number of 1024-bit chunks.
- Compares the neuron total against a threshold and emits a 1-bit activation plus the raw sum over a valid/ready handshake toward the activation buffer.

Parameters:
- IN_WIDTH, 11, width of the incoming popcount value (max 1024 per chunk); taken from the low bits of the popcount result bus.
- ACC_WIDTH, 20, width of the neuron accumulator, threshold and out_sum.
- CHUNK_CNT_WIDTH, 8, width of the chunk-count configuration and the internal chunk counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_chunks  in  CHUNK_CNT_WIDTH  chunks per neuron; 0 is treated as 1.
- cfg_threshold  in  ACC_WIDTH  activation threshold, unsigned.
- in_valid  in  1  in_count holds a valid chunk popcount.
- in_count  in  IN_WIDTH  chunk popcount from the popcount stage.
- in_ready  out  1  block accepts a chunk this cycle.
- out_valid  out  1  neuron result is available.
- out_ready  in  1  downstream accepts the result.
- out_bit  out  1  activation: 1 when out_sum >= threshold, else 0.
- out_sum  out  ACC_WIDTH  accumulated neuron popcount.
- busy  out  1  a neuron is partially accumulated (state ACCUM with chunk_idx != 0).

Behaviour:
- Reset and interface timing:
  - Single clock domain. Reset is synchronous, active-high, and sampled on the rising edge of clk.
  - Reset values: state=ACCUM, acc=0, chunk_idx=0, out_valid=0, out_bit=0, out_sum=0.
  - Reset forces in_ready=1 and busy=0 combinationally.
  - Reset mid-neuron or mid-EMIT discards the partial sum or pending result. No output is produced for it.
- Accept handshake:
  - A chunk is accepted when in_valid && in_ready at a rising edge.
- Configuration latch:
  - On the first chunk of a neuron (chunk_idx==0), cfg_chunks and cfg_threshold are latched into n_chunks and thr.
  - Config changes mid-neuron have no effect until the next neuron.
- State machine:
  - ACCUM:
    - in_ready=1.
    - On accept, acc_next = (chunk_idx==0 ? 0 : acc) + zero-extended in_count.
    - If chunk_idx+1 == n_chunks, go to EMIT. The result registers load out_sum=acc_next and out_bit=(acc_next >= thr), out_valid=1, and chunk_idx=0.
    - Otherwise chunk_idx increments and the state stays ACCUM.
  - EMIT:
    - out_valid=1. out_sum and out_bit are held stable until out_ready.
    - in_ready = out_ready (pass-through back-pressure).
    - If out_ready && !in_valid, go to ACCUM and clear out_valid.
    - If out_ready && in_valid, the result retires and the new chunk starts a new neuron in the same cycle (config is latched).
      - For a 1-chunk neuron, stay in EMIT with the new result, so out_valid remains 1.
      - Otherwise go to ACCUM with chunk_idx=1.
- Latency and throughput:
  - out_valid rises on the clock edge that accepts the last chunk, so the result is visible in the following cycle.
  - Throughput is one chunk per cycle with no bubbles when out_ready=1, including 1-chunk neurons.
- Arithmetic:
  - All values are unsigned.
  - The comparison uses the full ACC_WIDTH sum.
  - Overflow behaviour is set by the optional feature.
- Boundary conditions:
  - cfg_chunks=0 is treated as 1.
  - cfg_chunks=2^CHUNK_CNT_WIDTH-1 is supported.
  - in_count values above 1024 are accumulated unmodified and are not checked.

Optional Feature:
- Macro: POPACC_SAT_EN.
- Defined:
  - The adder saturates at 2^ACC_WIDTH-1.
  - Extra output port out_sat (1 bit) is set when any addition of the neuron saturated. It is held with the result and reset to 0.
- Undefined:
  - The accumulator wraps modulo 2^ACC_WIDTH.
  - No out_sat port exists.

Test Plan:
- Basic neuron: rst, cfg_chunks=4, cfg_threshold=2000, out_ready=1, in_count 512, 600, 400, 500 on consecutive cycles -> out_valid one cycle after the 4th accept, out_sum=2012, out_bit=1, busy=1 during chunks 2-4.
- Below threshold plus back-pressure: cfg_chunks=2, thr=1500, counts 700, 700, out_ready=0 for 5 cycles -> out_sum=1400, out_bit=0 held stable, in_ready=0, and a further in_valid is not accepted until out_ready=1.
- Back-to-back 1-chunk neurons: cfg_chunks=0 (treated as 1), thr=10, counts 9, 10, 1024 on consecutive cycles, out_ready=1 -> three consecutive results: 9/0, 10/1, 1024/1, with out_valid continuously high.
- Mid-neuron config change: cfg_chunks=3, thr=100; change to cfg_chunks=1 after the first chunk; counts 50, 30, 30 -> single result out_sum=110, out_bit=1.
- Reset mid-operation: 2 of 4 chunks accepted, assert rst for one cycle, then a fresh neuron 100x4 with thr=400 -> no stale output, out_sum=400, out_bit=1.
- Overflow: ACC_WIDTH=11, cfg_chunks=2, counts 1024, 1024 -> without POPACC_SAT_EN out_sum=0; with it out_sum=2047 and out_sat=1.
